gpio_event_arbiter: RTL and testbench

//  Shares one debounce timebase across N_BTN active-low push buttons.

---
 rtl/gpio_event_arbiter_pkg.sv | 50 +++++
 rtl/gpio_event_arbiter_channel.sv | 97 +++++++++
 rtl/gpio_event_arbiter.sv | 123 ++++++++++++
 tb/tb_gpio_event_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_event_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_event_arbiter_pkg
// Description : Shared constants, channel state encoding and the round-robin
//               pick helper for the GPIO event arbiter.
//               Contents: source clock rate, default tick/press/release
//               constants, ch_state_e, rr_pick().
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_event_arbiter_pkg;

  // Board source clock; default for the top-level CLK_HZ.
  localparam int unsigned C_SOURCE_CLK_HZ       = 50_000_000;
  localparam int unsigned C_DEF_TICK_HZ         = 1000;
  localparam int unsigned C_DEF_PRESS_TICKS     = 40;
  localparam int unsigned C_DEF_RELEASE_TICKS   = 20;

  // Width of the per-channel debounce counter (targets are <= 255).
  localparam int unsigned C_CNT_W               = 8;

  // Largest supported button count; sizes the pick helper.
  localparam int unsigned C_MAX_BTN             = 16;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_HELD = 1'b1
  } ch_state_e;

  // Round-robin pick: first set bit of req scanning from last+1 upward,
  // wrapping at n. Result is {found, index[3:0]}.
  function automatic logic [4:0] rr_pick(input logic [C_MAX_BTN-1:0] req,
                                         input int unsigned          last,
                                         input int unsigned          n);
    logic [4:0]  res;
    int unsigned cand;
    res  = '0;
    cand = 0;
    for (int unsigned k = 1; k <= C_MAX_BTN; k++) begin
      if (k <= n) begin
        cand = (last + k) % n;
        if (!res[4] && req[cand[3:0]]) begin
          res = {1'b1, cand[3:0]};
        end
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_event_arbiter_channel.sv
`default_nettype none
// ============================================================================
// Module      : gpio_event_arbiter_channel
// Description : One button channel: 2-flop synchroniser, IDLE/HELD debounce
//               state with a saturating-by-construction counter, and a
//               single-cycle press strobe.
//   src_clk   in  system clock
//   rst_n     in  synchronous reset, active low
//   btn_n     in  raw active-low button pin (asynchronous)
//   tick      in  debounce sample enable, one cycle wide
//   pressed   out debounced level, 1 = held
//   press_stb out one-cycle strobe on the tick that accepts a press
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_event_arbiter_channel
  import gpio_event_arbiter_pkg::*;
#(
  parameter int unsigned PRESS_TICKS   = C_DEF_PRESS_TICKS,
  parameter int unsigned RELEASE_TICKS = C_DEF_RELEASE_TICKS
) (
  input  logic src_clk,
  input  logic rst_n,
  input  logic btn_n,
  input  logic tick,
  output logic pressed,
  output logic press_stb
);

  // Compare against target-1 so the counter returns to 0 instead of ever
  // holding the target value itself.
  localparam logic [C_CNT_W-1:0] C_PRESS_LAST   = C_CNT_W'(PRESS_TICKS - 1);
  localparam logic [C_CNT_W-1:0] C_RELEASE_LAST = C_CNT_W'(RELEASE_TICKS - 1);

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  ch_state_e          state_q, state_d;
  logic [C_CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d   = btn_n;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_stb = 1'b0;
    if (tick) begin
      case (state_q)
        CH_IDLE: begin
          if (!sync2_q) begin
            if (cnt_q == C_PRESS_LAST) begin
              state_d   = CH_HELD;
              cnt_d     = '0;
              press_stb = 1'b1;
            end else begin
              cnt_d = cnt_q + C_CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        CH_HELD: begin
          if (sync2_q) begin
            if (cnt_q == C_RELEASE_LAST) begin
              state_d = CH_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + C_CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = CH_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge src_clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= CH_IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pressed = (state_q == CH_HELD);

endmodule
`default_nettype wire

// File: rtl/gpio_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gpio_event_arbiter
// Description : Debounces N_BTN active-low buttons on a shared tick and
//               round-robin arbitrates one event per press onto a
//               valid/ready stream.
//   src_clk     in  system clock (tick is only a clock enable)
//   rst_n       in  synchronous reset, active low
//   btn_n       in  raw button pins, active low
//   pressed     out debounced levels, 1 = held
//   evt_valid   out event presented on evt_idx
//   evt_ready   in  consumer accepts when evt_valid && evt_ready
//   evt_idx     out index of the pressed button
//   evt_overrun out one-cycle pulse: press while that button still pending
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_event_arbiter
  import gpio_event_arbiter_pkg::*;
#(
  parameter int unsigned CLK_HZ        = C_SOURCE_CLK_HZ,
  parameter int unsigned TICK_HZ       = C_DEF_TICK_HZ,
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned PRESS_TICKS   = C_DEF_PRESS_TICKS,
  parameter int unsigned RELEASE_TICKS = C_DEF_RELEASE_TICKS,
  parameter int unsigned IDX_W         = 2
) (
  input  logic             src_clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] pressed,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_idx,
  output logic             evt_overrun
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned TC_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TC_W-1:0] C_TICK_LAST = TC_W'(TICK_DIV - 1);

  logic [TC_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic             w_tick;
  logic [N_BTN-1:0] w_stb;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic             evt_valid_q, evt_valid_d;
  logic [IDX_W-1:0] evt_idx_q, evt_idx_d;
  logic             evt_overrun_q, evt_overrun_d;
  logic [4:0]       w_pick;
  logic [N_BTN-1:0] w_clr;

  // Shared timebase
  assign w_tick = (tick_cnt_q == C_TICK_LAST);

  always_comb begin
    tick_cnt_d = w_tick ? '0 : tick_cnt_q + TC_W'(1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_chan
      gpio_event_arbiter_channel #(
        .PRESS_TICKS   (PRESS_TICKS),
        .RELEASE_TICKS (RELEASE_TICKS)
      ) u_chan (
        .src_clk   (src_clk),
        .rst_n     (rst_n),
        .btn_n     (btn_n[gi]),
        .tick      (w_tick),
        .pressed   (pressed[gi]),
        .press_stb (w_stb[gi])
      );
    end
  endgenerate

  // Arbiter and pending set. The output register reloads whenever it is
  // empty or being consumed; otherwise everything holds.
  always_comb begin
    w_pick        = rr_pick(C_MAX_BTN'(pend_q), 32'(rr_q), N_BTN);
    w_clr         = '0;
    rr_d          = rr_q;
    evt_valid_d   = evt_valid_q;
    evt_idx_d     = evt_idx_q;
    if (!evt_valid_q || evt_ready) begin
      if (w_pick[4]) begin
        evt_valid_d = 1'b1;
        evt_idx_d   = IDX_W'(w_pick[3:0]);
        rr_d        = IDX_W'(w_pick[3:0]);
        w_clr       = N_BTN'(1) << w_pick[3:0];
      end else begin
        evt_valid_d = 1'b0;
      end
    end
    // A strobe landing on the bit being cleared re-sets it, so the new
    // press survives.
    pend_d        = (pend_q & ~w_clr) | w_stb;
    evt_overrun_d = |(w_stb & pend_q);
  end

  always_ff @(posedge src_clk) begin
    if (!rst_n) begin
      tick_cnt_q    <= '0;
      pend_q        <= '0;
      rr_q          <= '0;
      evt_valid_q   <= 1'b0;
      evt_idx_q     <= '0;
      evt_overrun_q <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      pend_q        <= pend_d;
      rr_q          <= rr_d;
      evt_valid_q   <= evt_valid_d;
      evt_idx_q     <= evt_idx_d;
      evt_overrun_q <= evt_overrun_d;
    end
  end

  assign evt_valid   = evt_valid_q;
  assign evt_idx     = evt_idx_q;
  assign evt_overrun = evt_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_event_arbiter
// Description : Self-checking bench for gpio_event_arbiter with a
//               cycle-level behavioural model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_event_arbiter;

  localparam int NB = 4;
  localparam int DIV = 10;

  logic          src_clk;
  logic          rst_n;
  logic [NB-1:0] btn_n;
  logic [NB-1:0] pressed;
  logic          evt_valid;
  logic          evt_ready;
  logic [1:0]    evt_idx;
  logic          evt_overrun;

  gpio_event_arbiter #(
    .CLK_HZ        (1000),
    .TICK_HZ       (100),
    .N_BTN         (NB),
    .PRESS_TICKS   (4),
    .RELEASE_TICKS (2),
    .IDX_W         (2)
  ) dut (
    .src_clk     (src_clk),
    .rst_n       (rst_n),
    .btn_n       (btn_n),
    .pressed     (pressed),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_idx     (evt_idx),
    .evt_overrun (evt_overrun)
  );

  initial src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_tc;
  bit [NB-1:0] m_s1, m_s2;
  int          m_cnt [NB];
  bit [NB-1:0] m_held;
  bit [NB-1:0] m_pend;
  int          m_rr;
  bit          m_valid;
  int          m_idx;
  bit          m_ovr;

  always @(posedge src_clk) begin : model
    bit          tk;
    bit [NB-1:0] stb;
    bit [NB-1:0] clr;
    int          w;
    if (!rst_n) begin
      m_tc = 0; m_s1 = '1; m_s2 = '1; m_held = '0; m_pend = '0;
      m_rr = 0; m_valid = 0; m_idx = 0; m_ovr = 0;
      for (int i = 0; i < NB; i++) m_cnt[i] = 0;
    end else begin
      tk  = (m_tc == DIV - 1);
      stb = '0;
      if (tk) begin
        for (int i = 0; i < NB; i++) begin
          if (!m_held[i]) begin
            if (!m_s2[i]) begin
              m_cnt[i]++;
              if (m_cnt[i] == 4) begin m_held[i] = 1; m_cnt[i] = 0; stb[i] = 1; end
            end else m_cnt[i] = 0;
          end else begin
            if (m_s2[i]) begin
              m_cnt[i]++;
              if (m_cnt[i] == 2) begin m_held[i] = 0; m_cnt[i] = 0; end
            end else m_cnt[i] = 0;
          end
        end
      end
      m_tc = tk ? 0 : m_tc + 1;
      m_s2 = m_s1;
      m_s1 = btn_n;
      clr  = '0;
      if (!m_valid || evt_ready) begin
        w = -1;
        for (int k = 1; k <= NB; k++)
          if (w < 0 && m_pend[(m_rr + k) % NB]) w = (m_rr + k) % NB;
        if (w >= 0) begin
          m_valid = 1; m_idx = w; m_rr = w; clr[w] = 1;
        end else m_valid = 0;
      end
      m_ovr  = |(stb & m_pend);
      m_pend = (m_pend & ~clr) | stb;
    end
  end

  // ---------------- compare + monitor ----------------
  int   log_q [$];
  int   ovr_cnt = 0;
  int   cyc = 0;
  int   rise_p1 = -1, rise_v = -1;
  logic prev_p1 = 0, prev_v = 0;

  always @(negedge src_clk) begin
    cyc++;
    chk("pressed", 32'(pressed), 32'(m_held));
    chk("evt_valid", 32'(evt_valid), 32'(m_valid));
    if (m_valid) chk("evt_idx", 32'(evt_idx), 32'(m_idx));
    chk("evt_overrun", 32'(evt_overrun), 32'(m_ovr));
    if (evt_valid === 1'b1 && evt_ready === 1'b1) log_q.push_back(int'(evt_idx));
    if (evt_overrun === 1'b1) ovr_cnt++;
    if (pressed[1] === 1'b1 && !prev_p1) rise_p1 = cyc;
    if (evt_valid === 1'b1 && !prev_v) rise_v = cyc;
    prev_p1 = pressed[1];
    prev_v  = evt_valid;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge src_clk);
      #2;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int base;
    int ov0;
    rst_n = 0; btn_n = '1; evt_ready = 0;

    // 1: reset
    cycles(5);
    chk("rst_pressed", 32'(pressed), 0);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_idx", 32'(evt_idx), 0);
    chk("rst_ovr", 32'(evt_overrun), 0);
    rst_n = 1;
    cycles(3);
    chk("post_rst_valid", 32'(evt_valid), 0);
    chk("post_rst_pressed", 32'(pressed), 0);

    // 2: single press of button 1
    evt_ready = 1;
    base = log_q.size();
    btn_n = 4'b1101;
    cycles(60);
    chk("t2_pressed1", 32'(pressed[1]), 1);
    chk("t2_nevents", 32'(log_q.size() - base), 1);
    if (log_q.size() > base) chk("t2_idx", 32'(log_q[base]), 1);
    chk("t2_latency", 32'(rise_v - rise_p1), 1);
    btn_n = '1;
    cycles(40);
    chk("t2_released", 32'(pressed[1]), 0);

    // 3: bounce on button 0, two ticks per level
    base = log_q.size();
    for (int i = 0; i < 10; i++) begin
      btn_n[0] = (i % 2 == 1);
      cycles(20);
    end
    btn_n = '1;
    cycles(40);
    chk("t3_pressed0", 32'(pressed[0]), 0);
    chk("t3_nevents", 32'(log_q.size() - base), 0);

    // park rr at 3 so the next scan starts at 0
    btn_n = 4'b0111;
    cycles(60);
    btn_n = '1;
    cycles(40);
    chk("pre4_idx3", 32'(log_q[log_q.size() - 1]), 3);

    // 4: round robin among 0,2,3 pressed together
    evt_ready = 0;
    base = log_q.size();
    btn_n = 4'b0010;
    cycles(60);
    chk("t4_valid_held", 32'(evt_valid), 1);
    chk("t4_idx_held", 32'(evt_idx), 0);
    evt_ready = 1;
    cycles(4);
    chk("t4_nevents", 32'(log_q.size() - base), 3);
    if (log_q.size() >= base + 3) begin
      chk("t4_first", 32'(log_q[base]), 0);
      chk("t4_second", 32'(log_q[base + 1]), 2);
      chk("t4_third", 32'(log_q[base + 2]), 3);
    end
    btn_n = '1;
    cycles(40);

    // 5: overrun on button 2 while button 1 occupies the stream
    evt_ready = 0;
    base = log_q.size();
    ov0  = ovr_cnt;
    btn_n = 4'b1101; cycles(60);
    btn_n = '1;      cycles(40);
    btn_n = 4'b1011; cycles(60);
    btn_n = '1;      cycles(40);
    btn_n = 4'b1011; cycles(60);
    btn_n = '1;      cycles(40);
    chk("t5_overruns", 32'(ovr_cnt - ov0), 1);
    evt_ready = 1;
    cycles(5);
    chk("t5_nevents", 32'(log_q.size() - base), 2);
    if (log_q.size() >= base + 2) begin
      chk("t5_first", 32'(log_q[base]), 1);
      chk("t5_second", 32'(log_q[base + 1]), 2);
    end

    // 6: reset mid-handshake with another press pending
    evt_ready = 0;
    btn_n = 4'b0110;
    cycles(60);
    chk("t6_valid", 32'(evt_valid), 1);
    chk("t6_idx", 32'(evt_idx), 3);
    btn_n = '1;
    cycles(2);
    rst_n = 0;
    cycles(1);
    rst_n = 1;
    chk("t6_valid_dropped", 32'(evt_valid), 0);
    base = log_q.size();
    evt_ready = 1;
    cycles(5);
    chk("t6_pend_dropped", 32'(log_q.size() - base), 0);
    chk("t6_valid_idle", 32'(evt_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
